// File: rtl/truth_table_checker_pkg.sv
// Shared types and defaults for truth_table_checker: FSM state encoding and
// the default input count / truth-table size.
package truth_table_checker_pkg;

  localparam int N_IN_DEFAULT  = 3;
  localparam int CNT_W_DEFAULT = 4;
  localparam int N_VEC         = 2 ** N_IN_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/truth_table_checker_if.sv
// Stimulus/result bundle between a gate bench and truth_table_checker.
// TRUTH_TABLE_CHECKER_FAIL_MASK_EN adds the per-index fail_mask result.
interface truth_table_checker_if
  import truth_table_checker_pkg::*;
#(
  parameter int N_IN  = N_IN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic                   start;
  logic                   in_valid;
  logic [N_IN-1:0]        in_vec;
  logic                   in_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [CNT_W-1:0]       err_count;
  logic                   first_fail_valid;
  logic [N_IN-1:0]        first_fail_idx;
  logic [(2**N_IN)-1:0]   coverage;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
  logic [(2**N_IN)-1:0]   fail_mask;
`endif

  modport master (
    output start, in_valid, in_vec, in_out,
    input  busy, done, pass, err_count, first_fail_valid, first_fail_idx, coverage
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
    , input fail_mask
`endif
  );

  modport slave (
    input  start, in_valid, in_vec, in_out,
    output busy, done, pass, err_count, first_fail_valid, first_fail_idx, coverage
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
    , output fail_mask
`endif
  );

endinterface

// File: rtl/truth_table_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: reset/clear to zero, increment until all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Hardware response checker: compares a gate's output against EXPECT and
// tracks input coverage. TRUTH_TABLE_CHECKER_FAIL_MASK_EN adds fail_mask.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                  N_IN   = N_IN_DEFAULT,
  parameter logic [(2**N_IN)-1:0] EXPECT = 8'h96,
  parameter int                  CNT_W  = CNT_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  truth_table_checker_if.slave bus
);

  localparam int NV = 2 ** N_IN;

  state_t            state_r;
  state_t            state_next_s;
  logic [NV-1:0]     coverage_r;
  logic [NV-1:0]     cov_next_s;
  logic [NV-1:0]     sample_hot_s;
  logic              sample_s;
  logic              mismatch_s;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic              ffv_r;
  logic [N_IN-1:0]   ffi_r;
  logic [CNT_W-1:0]  err_count_s;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
  logic [NV-1:0]     fail_mask_r;
`endif

  // Sample qualification and next-state; start outranks a same-cycle sample.
  always_comb begin
    sample_s     = (state_r == CHECK) && bus.in_valid && !bus.start;
    mismatch_s   = sample_s && (bus.in_out != EXPECT[bus.in_vec]);
    sample_hot_s = {NV{1'b0}};
    if (sample_s) begin
      sample_hot_s[bus.in_vec] = 1'b1;
    end else begin
      sample_hot_s = {NV{1'b0}};
    end
    cov_next_s   = coverage_r | sample_hot_s;
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = bus.start ? CHECK : IDLE;
      CHECK: begin
        if (bus.start) begin
          state_next_s = CHECK;
        end else if (&cov_next_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CHECK;
        end
      end
      DONE:    state_next_s = bus.start ? CHECK : DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, coverage, first-failure latch and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      coverage_r  <= {NV{1'b0}};
      ffv_r       <= 1'b0;
      ffi_r       <= {N_IN{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
      fail_mask_r <= {NV{1'b0}};
`endif
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == CHECK);
      done_r  <= (state_next_s == DONE);
      // The counter updates on this same edge, so fold in this cycle's mismatch.
      pass_r  <= (state_next_s == DONE) && (err_count_s == {CNT_W{1'b0}}) && !mismatch_s;
      if (bus.start) begin
        coverage_r  <= {NV{1'b0}};
        ffv_r       <= 1'b0;
        ffi_r       <= {N_IN{1'b0}};
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
        fail_mask_r <= {NV{1'b0}};
`endif
      end else begin
        coverage_r <= cov_next_s;
        if (mismatch_s && !ffv_r) begin
          ffv_r <= 1'b1;
          ffi_r <= bus.in_vec;
        end else begin
          ffv_r <= ffv_r;
          ffi_r <= ffi_r;
        end
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
        fail_mask_r <= fail_mask_r | (mismatch_s ? sample_hot_s : {NV{1'b0}});
`endif
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.start),
    .inc   (mismatch_s),
    .count (err_count_s)
  );

  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.pass             = pass_r;
  assign bus.err_count        = err_count_s;
  assign bus.first_fail_valid = ffv_r;
  assign bus.first_fail_idx   = ffi_r;
  assign bus.coverage         = coverage_r;
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
  assign bus.fail_mask        = fail_mask_r;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker (3-input odd-parity table):
// directed vector table, corner sequences and randomized runs vs. a model.
module tb_truth_table_checker;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  truth_table_checker_if #(.N_IN(3), .CNT_W(4)) bus ();

  truth_table_checker #(.N_IN(3), .EXPECT(8'h96), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: odd parity of the 3 input bits, plain counters and sets.
  bit        m_run;
  bit        m_fin;
  bit [7:0]  m_cov;
  bit [7:0]  m_fm;
  int        m_err;
  int        m_first;

  typedef struct {
    logic      r, s, v;
    int        vec;
    logic      o;
    logic      e_busy, e_done, e_pass;
    int        e_err;
    logic [7:0] e_cov;
  } vec_t;

  vec_t tbl[$];

  function automatic logic parity(input int vec);
    logic [2:0] b;
    b = vec[2:0];
    return logic'($countones(b) % 2);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic v, input int vec, input logic o);
    if (r) begin
      m_run = 0; m_fin = 0; m_cov = '0; m_fm = '0; m_err = 0; m_first = -1;
    end else if (s) begin
      m_run = 1; m_fin = 0; m_cov = '0; m_fm = '0; m_err = 0; m_first = -1;
    end else if (m_run && v) begin
      m_cov[vec] = 1'b1;
      if (o != parity(vec)) begin
        m_err = (m_err < 15) ? m_err + 1 : 15;
        if (m_first < 0) m_first = vec;
        m_fm[vec] = 1'b1;
      end
      if (m_cov == 8'hFF) begin
        m_run = 0;
        m_fin = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("busy", int'(bus.busy), int'(m_run));
    chk("done", int'(bus.done), int'(m_fin));
    chk("pass", int'(bus.pass), int'(m_fin && m_err == 0));
    chk("err_count", int'(bus.err_count), m_err);
    chk("coverage", int'(bus.coverage), int'(m_cov));
    chk("first_fail_valid", int'(bus.first_fail_valid), int'(m_first >= 0));
    chk("first_fail_idx", int'(bus.first_fail_idx), (m_first >= 0) ? m_first : 0);
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
    chk("fail_mask", int'(bus.fail_mask), int'(m_fm));
`endif
  endtask

  task automatic apply(input logic r, input logic s, input logic v, input int vec, input logic o);
    rst          = r;
    bus.start    = s;
    bus.in_valid = v;
    bus.in_vec   = vec[2:0];
    bus.in_out   = o;
    @(posedge clk);
    model_step(r, s, v, vec, o);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic v, input int vec, input logic o,
                              input logic eb, input logic ed, input logic ep, input int ee, input logic [7:0] ec);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.vec = vec; t.o = o;
    t.e_busy = eb; t.e_done = ed; t.e_pass = ep; t.e_err = ee; t.e_cov = ec;
    return t;
  endfunction

  initial begin
    int c;
    logic [7:0] cv;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_vec = 3'd0; bus.in_out = 1'b0;
    m_first = -1;

    // Directed table: reset, a clean run, then a run with faults at 3 and 5.
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00));
    for (int i = 0; i < 8; i++) begin
      c  = (1 << (i + 1)) - 1;
      cv = c[7:0];
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, i, parity(i), logic'(i < 7), logic'(i == 7), logic'(i == 7), 0, cv));
    end
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00));
    for (int i = 0; i < 8; i++) begin
      c  = (1 << (i + 1)) - 1;
      cv = c[7:0];
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, i, parity(i) ^ logic'(i == 3 || i == 5),
                       logic'(i < 7), logic'(i == 7), 1'b0, (i >= 5) ? 2 : ((i >= 3) ? 1 : 0), cv));
    end

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].r, tbl[k].s, tbl[k].v, tbl[k].vec, tbl[k].o);
      chk("tbl_busy", int'(bus.busy), int'(tbl[k].e_busy));
      chk("tbl_done", int'(bus.done), int'(tbl[k].e_done));
      chk("tbl_pass", int'(bus.pass), int'(tbl[k].e_pass));
      chk("tbl_err", int'(bus.err_count), tbl[k].e_err);
      chk("tbl_cov", int'(bus.coverage), int'(tbl[k].e_cov));
    end
    chk("fault_first_idx", int'(bus.first_fail_idx), 3);
    chk("fault_first_valid", int'(bus.first_fail_valid), 1);
`ifdef TRUTH_TABLE_CHECKER_FAIL_MASK_EN
    chk("fault_mask", int'(bus.fail_mask), 8'h28);
`endif

    // DONE holds: a stray wrong sample changes nothing.
    apply(1'b0, 1'b0, 1'b1, 3, ~parity(3));
    chk("done_hold_err", int'(bus.err_count), 2);
    chk("done_hold_done", int'(bus.done), 1);

    // Duplicates and saturation.
    apply(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 1'b1, 2, ~parity(2));
    chk("sat_err", int'(bus.err_count), 15);
    chk("sat_cov", int'(bus.coverage), 8'h04);
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b0, 1'b1, i, parity(i));
    chk("sat_not_done", int'(bus.done), 0);
    chk("sat_err_hold", int'(bus.err_count), 15);
    apply(1'b0, 1'b0, 1'b1, 7, parity(7));
    chk("sat_done", int'(bus.done), 1);
    chk("sat_pass", int'(bus.pass), 0);
    chk("sat_first_idx", int'(bus.first_fail_idx), 2);

    // Mid-run reset, then in_valid without start is ignored.
    apply(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 1'b1, i, ~parity(i));
    apply(1'b1, 1'b0, 1'b1, 5, 1'b0);
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_cov", int'(bus.coverage), 8'h00);
    chk("mrst_err", int'(bus.err_count), 0);
    apply(1'b0, 1'b0, 1'b1, 6, ~parity(6));
    chk("idle_ign_cov", int'(bus.coverage), 8'h00);
    chk("idle_ign_err", int'(bus.err_count), 0);
    chk("idle_ign_busy", int'(bus.busy), 0);

    // Restart in CHECK with a same-cycle sample: sample discarded.
    apply(1'b0, 1'b1, 1'b0, 0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1, ~parity(1));
    apply(1'b0, 1'b0, 1'b1, 4, parity(4));
    apply(1'b0, 1'b1, 1'b1, 6, ~parity(6));
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_cov", int'(bus.coverage), 8'h00);
    chk("restart_err", int'(bus.err_count), 0);
    chk("restart_ffv", int'(bus.first_fail_valid), 0);

    // Randomized runs against the model.
    for (int run = 0; run < 8; run++) begin
      apply(1'b0, 1'b1, 1'b0, 0, 1'b0);
      for (int k = 0; k < 150; k++) begin
        int vec;
        vec = int'($urandom_range(0, 7));
        apply(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 59) == 0),
              logic'($urandom_range(0, 3) != 0), vec,
              parity(vec) ^ logic'($urandom_range(0, 9) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
